// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - unsigned restoring shift/subtract divider, one quotient bit per cycle
module shift_sub_divider #(
    parameter int SIZE = 32
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [SIZE-1:0] Data_A,
    input  logic [SIZE-1:0] Data_B,
    output logic [SIZE-1:0] Quotient,
    output logic [SIZE-1:0] Remainder,
    output logic            Busy,
    output logic            Done,
    output logic            Div_Zero
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [SIZE-1:0] quo_q;
    logic [SIZE-1:0] rem_q;
    logic [SIZE-1:0] div_q;
    logic            busy_q;
    logic            done_q;
    logic            dz_q;

    logic [SIZE:0]   shifted_rem;
    logic [SIZE-1:0] quo_d;
    logic [SIZE-1:0] rem_d;

    // The shifted partial remainder keeps its carry-out bit so divisors with
    // the MSB set compare correctly; the difference always fits in SIZE bits.
    always_comb begin
        shifted_rem = {rem_q, quo_q[SIZE-1]};
        quo_d       = quo_q << 1;
        rem_d       = shifted_rem[SIZE-1:0];
        if (shifted_rem >= {1'b0, div_q}) begin
            rem_d = shifted_rem[SIZE-1:0] - div_q;
            quo_d = (quo_q << 1) | SIZE'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        if (Data_B == '0) begin
                            quo_q   <= '1;
                            rem_q   <= Data_A;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            quo_q   <= Data_A;
                            div_q   <= Data_B;
                            rem_q   <= '0;
                            dz_q    <= 1'b0;
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    quo_q   <= quo_d;
                    rem_q   <= rem_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Div_Zero  = dz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// tb/tb_shift_sub_divider.sv - directed and randomized checks of shift_sub_divider against an arithmetic model
module tb_shift_sub_divider;

    localparam int SIZE = 32;

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic            Start = 1'b0;
    logic [SIZE-1:0] Data_A = '0;
    logic [SIZE-1:0] Data_B = '0;
    logic [SIZE-1:0] Quotient;
    logic [SIZE-1:0] Remainder;
    logic            Busy;
    logic            Done;
    logic            Div_Zero;

    int checks = 0;
    int passed = 0;

    shift_sub_divider #(.SIZE(SIZE)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Data_A   (Data_A),
        .Data_B   (Data_B),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .Busy     (Busy),
        .Done     (Done),
        .Div_Zero (Div_Zero)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Issues one Start, optionally re-pulses Start with other operands at
    // cycle restart_at, then checks latency, Busy span and result.
    task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input int restart_at, input bit full);
        logic [SIZE-1:0] eq;
        logic [SIZE-1:0] er;
        int cycles;
        int busy_cnt;
        eq = (b == 0) ? '1 : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge Clock);
        Start  = 1'b1;
        Data_A = a;
        Data_B = b;
        @(negedge Clock);
        Start  = 1'b0;
        Data_A = $urandom;
        Data_B = $urandom;
        cycles   = 1;
        busy_cnt = 0;
        while (!Done && cycles < 100) begin
            if (Busy) busy_cnt++;
            Start = (cycles == restart_at);
            if (cycles == restart_at) begin
                Data_A = 50;
                Data_B = 5;
            end
            @(negedge Clock);
            Start = 1'b0;
            cycles++;
        end
        chk("latency", 64'(cycles), (b == 0) ? 64'd1 : 64'(SIZE + 1));
        chk("quotient", 64'(Quotient), 64'(eq));
        chk("remainder", 64'(Remainder), 64'(er));
        if (full) begin
            chk("div_zero", 64'(Div_Zero), 64'(b == 0));
            chk("busy_cycles", 64'(busy_cnt), (b == 0) ? 64'd0 : 64'(SIZE));
            chk("busy_in_done", 64'(Busy), 64'd0);
            @(negedge Clock);
            chk("done_pulse_width", 64'(Done), 64'd0);
            chk("quotient_hold", 64'(Quotient), 64'(eq));
            chk("remainder_hold", 64'(Remainder), 64'(er));
        end else begin
            @(negedge Clock);
        end
    endtask

    initial begin
        int cycles;
        int seen_done;
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;

        #1;
        chk("reset_quotient", 64'(Quotient), 64'd0);
        chk("reset_remainder", 64'(Remainder), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_div_zero", 64'(Div_Zero), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        run_op(32'd100, 32'd7, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b1);
        run_op(32'd5, 32'd9, 0, 1'b1);
        run_op(32'd0, 32'd3, 0, 1'b1);
        run_op(32'd1234, 32'd0, 0, 1'b1);
        run_op(32'd100, 32'd7, 10, 1'b1);

        // Abort mid-run with an asynchronous reset.
        @(negedge Clock);
        Start  = 1'b1;
        Data_A = 32'd100;
        Data_B = 32'd7;
        @(negedge Clock);
        Start = 1'b0;
        repeat (10) @(negedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        chk("abort_quotient", 64'(Quotient), 64'd0);
        chk("abort_remainder", 64'(Remainder), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_div_zero", 64'(Div_Zero), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) seen_done++;
            @(negedge Clock);
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        run_op(32'd81, 32'd9, 0, 1'b1);

        // Start held high: a second operation begins right after DONE.
        @(negedge Clock);
        Start  = 1'b1;
        Data_A = 32'd20;
        Data_B = 32'd3;
        cycles = 0;
        @(negedge Clock);
        Data_A = 32'd21;
        Data_B = 32'd4;
        while (!Done && cycles < 100) begin
            @(negedge Clock);
            cycles++;
        end
        chk("held_first_quotient", 64'(Quotient), 64'd6);
        chk("held_first_remainder", 64'(Remainder), 64'd2);
        @(negedge Clock);
        chk("held_idle_busy", 64'(Busy), 64'd0);
        @(negedge Clock);
        chk("held_restart_busy", 64'(Busy), 64'd1);
        Start = 1'b0;
        cycles = 0;
        while (!Done && cycles < 100) begin
            @(negedge Clock);
            cycles++;
        end
        chk("held_second_quotient", 64'(Quotient), 64'd5);
        chk("held_second_remainder", 64'(Remainder), 64'd1);
        @(negedge Clock);

        for (int i = 0; i < 800; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = $urandom_range(1, 15);
                1: rb = rb >> $urandom_range(1, 31);
                2: ra = ra >> $urandom_range(1, 31);
                3: rb = 32'h8000_0000 | rb;
                4: if ($urandom_range(0, 3) == 0) rb = '0;
                default: ;
            endcase
            run_op(ra, rb, 0, (i % 50) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
